// File: rtl/video_tg_pkg.sv
// rtl/video_tg_pkg.sv - shared timing struct, standard mode constants and colour-bar palette for the video timing generator
package video_tg_pkg;

    localparam int TG_W = 12;

    typedef struct packed {
        logic [TG_W-1:0] h_total;
        logic [TG_W-1:0] h_sync;
        logic [TG_W-1:0] h_bporch;
        logic [TG_W-1:0] h_res;
        logic [TG_W-1:0] v_total;
        logic [TG_W-1:0] v_sync;
        logic [TG_W-1:0] v_bporch;
        logic [TG_W-1:0] v_res;
    } timing_t;

    localparam timing_t TIMING_720P = '{
        h_total: 12'd1650, h_sync: 12'd40, h_bporch: 12'd220, h_res: 12'd1280,
        v_total: 12'd750,  v_sync: 12'd5,  v_bporch: 12'd20,  v_res: 12'd720};
    localparam timing_t TIMING_1024X768 = '{
        h_total: 12'd1344, h_sync: 12'd136, h_bporch: 12'd160, h_res: 12'd1024,
        v_total: 12'd806,  v_sync: 12'd6,   v_bporch: 12'd29,  v_res: 12'd768};
    localparam timing_t TIMING_800X600 = '{
        h_total: 12'd1056, h_sync: 12'd128, h_bporch: 12'd88, h_res: 12'd800,
        v_total: 12'd628,  v_sync: 12'd4,   v_bporch: 12'd23, v_res: 12'd600};

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = BAR_WHITE;
            3'd1:    bar_colour = BAR_YELLOW;
            3'd2:    bar_colour = BAR_CYAN;
            3'd3:    bar_colour = BAR_GREEN;
            3'd4:    bar_colour = BAR_MAGENTA;
            3'd5:    bar_colour = BAR_RED;
            3'd6:    bar_colour = BAR_BLUE;
            default: bar_colour = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_tg_axis_cnt.sv
// rtl/video_tg_axis_cnt.sv - one timing axis: position counter with sync, active window and relative position
//
// Ports:
//   I_clk, I_rst_n            pixel clock, async active-low reset
//   I_adv                     advance the counter this cycle
//   I_total/sync/bporch/res   shadowed axis timing
//   O_pos                     counter minus active start (meaningful while O_act)
//   O_first / O_last          counter at 0 / at total-1
//   O_sync                    counter inside sync pulse
//   O_act                     counter inside active window
module video_tg_axis_cnt
    import video_tg_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_adv,
    input  logic [CNT_W-1:0] I_total,
    input  logic [CNT_W-1:0] I_sync,
    input  logic [CNT_W-1:0] I_bporch,
    input  logic [CNT_W-1:0] I_res,
    output logic [CNT_W-1:0] O_pos,
    output logic             O_first,
    output logic             O_last,
    output logic             O_sync,
    output logic             O_act
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   start;
    logic [CNT_W+1:0] stop;

    // Extra width so sync+bporch+res never wraps for large programmed values.
    assign start   = {1'b0, I_sync} + {1'b0, I_bporch};
    assign stop    = {1'b0, start} + {2'b00, I_res};
    assign O_first = (cnt_q == '0);
    assign O_last  = (cnt_q == I_total - 1'b1);
    assign O_sync  = (cnt_q < I_sync);
    assign O_act   = ({1'b0, cnt_q} >= start) && ({2'b00, cnt_q} < stop);
    assign O_pos   = cnt_q - start[CNT_W-1:0];

    always_comb begin
        cnt_d = cnt_q;
        if (I_adv) begin
            cnt_d = O_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - runtime-programmable HS/VS/DE timing generator with pixel request and DE-aligned data
//
// Ports:
//   I_clk, I_rst_n            pixel clock, async active-low reset
//   I_h_*/I_v_*               requested timing, sampled only at the frame boundary
//   I_hs_pol, I_vs_pol        1 = positive sync
//   I_pix_data                pixel returned one cycle after O_req
//   I_pat_en                  colour bars instead of I_pix_data (VIDEO_TG_PATTERN_EN builds only)
//   O_req, O_x, O_y           early pixel request and its coordinate
//   O_hs, O_vs, O_de, O_rgb   timing outputs, O_de two cycles after O_req
//   O_frame_start, O_frame_cnt frame pulse and counter
//   O_cfg_err                 last sampled configuration was rejected
// Build option: define VIDEO_TG_PATTERN_EN to add the colour-bar generator.
module video_timing_gen
    import video_tg_pkg::*;
#(
    parameter int CNT_W        = 12,
    parameter int PIX_W        = 24,
    parameter int FCNT_W       = 16,
    parameter int RST_H_TOTAL  = 1650,
    parameter int RST_H_SYNC   = 40,
    parameter int RST_H_BPORCH = 220,
    parameter int RST_H_RES    = 1280,
    parameter int RST_V_TOTAL  = 750,
    parameter int RST_V_SYNC   = 5,
    parameter int RST_V_BPORCH = 20,
    parameter int RST_V_RES    = 720
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [CNT_W-1:0]  I_h_total,
    input  logic [CNT_W-1:0]  I_h_sync,
    input  logic [CNT_W-1:0]  I_h_bporch,
    input  logic [CNT_W-1:0]  I_h_res,
    input  logic [CNT_W-1:0]  I_v_total,
    input  logic [CNT_W-1:0]  I_v_sync,
    input  logic [CNT_W-1:0]  I_v_bporch,
    input  logic [CNT_W-1:0]  I_v_res,
    input  logic              I_hs_pol,
    input  logic              I_vs_pol,
    input  logic [PIX_W-1:0]  I_pix_data,
`ifdef VIDEO_TG_PATTERN_EN
    input  logic              I_pat_en,
`endif
    output logic              O_req,
    output logic [CNT_W-1:0]  O_x,
    output logic [CNT_W-1:0]  O_y,
    output logic              O_hs,
    output logic              O_vs,
    output logic              O_de,
    output logic [PIX_W-1:0]  O_rgb,
    output logic              O_frame_start,
    output logic [FCNT_W-1:0] O_frame_cnt,
    output logic              O_cfg_err
);

    logic [CNT_W-1:0] h_total_q, h_sync_q, h_bporch_q, h_res_q;
    logic [CNT_W-1:0] v_total_q, v_sync_q, v_bporch_q, v_res_q;
    logic [CNT_W-1:0] h_total_d, h_sync_d, h_bporch_d, h_res_d;
    logic [CNT_W-1:0] v_total_d, v_sync_d, v_bporch_d, v_res_d;
    logic             cfg_err_q, cfg_err_d;

    logic             req_q, hs0_q, vs0_q, fs0_q;
    logic             req_d, hs0_d, vs0_d, fs0_d;
    logic [CNT_W-1:0] x_q, y_q, x_d, y_d;
    logic             act1_q, hs1_q, vs1_q, fs1_q;
    logic             de_q, hs2_q, vs2_q, fs2_q;
    logic [PIX_W-1:0] rgb_q, rgb_d, pix_sel;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [CNT_W-1:0] h_pos, v_pos;
    logic             h_first, h_last, h_sync_a, h_act;
    logic             v_first, v_last, v_sync_a, v_act;
    logic [CNT_W+1:0] h_need, v_need;
    logic             cfg_ok;

    video_tg_axis_cnt #(.CNT_W(CNT_W)) u_h_cnt (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_adv(1'b1),
        .I_total(h_total_q), .I_sync(h_sync_q), .I_bporch(h_bporch_q), .I_res(h_res_q),
        .O_pos(h_pos), .O_first(h_first), .O_last(h_last), .O_sync(h_sync_a), .O_act(h_act)
    );

    video_tg_axis_cnt #(.CNT_W(CNT_W)) u_v_cnt (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_adv(h_last),
        .I_total(v_total_q), .I_sync(v_sync_q), .I_bporch(v_bporch_q), .I_res(v_res_q),
        .O_pos(v_pos), .O_first(v_first), .O_last(v_last), .O_sync(v_sync_a), .O_act(v_act)
    );

    assign h_need = {2'b00, I_h_sync} + {2'b00, I_h_bporch} + {2'b00, I_h_res};
    assign v_need = {2'b00, I_v_sync} + {2'b00, I_v_bporch} + {2'b00, I_v_res};
    assign cfg_ok = ({2'b00, I_h_total} >= h_need) && ({2'b00, I_v_total} >= v_need)
                  && (I_h_res != '0) && (I_v_res != '0)
                  && (I_h_sync != '0) && (I_v_sync != '0);

`ifdef VIDEO_TG_PATTERN_EN
    logic [2:0]       bar_q, bar_d;
    logic [CNT_W+2:0] bar_quot;

    // Bar index from the registered x so the colour lines up with stage 1 data.
    assign bar_quot = {x_q, 3'b000} / {3'b000, h_res_q};
    assign bar_d    = bar_quot[2:0];
    assign pix_sel  = I_pat_en ? PIX_W'(bar_colour(bar_q)) : I_pix_data;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            bar_q <= '0;
        end else begin
            bar_q <= bar_d;
        end
    end
`else
    assign pix_sel = I_pix_data;
`endif

    always_comb begin
        h_total_d  = h_total_q;
        h_sync_d   = h_sync_q;
        h_bporch_d = h_bporch_q;
        h_res_d    = h_res_q;
        v_total_d  = v_total_q;
        v_sync_d   = v_sync_q;
        v_bporch_d = v_bporch_q;
        v_res_d    = v_res_q;
        cfg_err_d  = cfg_err_q;
        // Shadows change only as both counters wrap, so a frame never mixes modes.
        if (h_last && v_last) begin
            if (cfg_ok) begin
                h_total_d  = I_h_total;
                h_sync_d   = I_h_sync;
                h_bporch_d = I_h_bporch;
                h_res_d    = I_h_res;
                v_total_d  = I_v_total;
                v_sync_d   = I_v_sync;
                v_bporch_d = I_v_bporch;
                v_res_d    = I_v_res;
                cfg_err_d  = 1'b0;
            end else begin
                cfg_err_d  = 1'b1;
            end
        end

        req_d = h_act && v_act;
        hs0_d = h_sync_a;
        vs0_d = v_sync_a;
        fs0_d = h_first && v_first;
        x_d   = req_d ? h_pos : x_q;
        y_d   = req_d ? v_pos : y_q;

        rgb_d = act1_q ? pix_sel : '0;
        // Counter steps on the same edge that raises O_frame_start.
        frame_cnt_d = fs1_q ? frame_cnt_q + 1'b1 : frame_cnt_q;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_total_q   <= CNT_W'(RST_H_TOTAL);
            h_sync_q    <= CNT_W'(RST_H_SYNC);
            h_bporch_q  <= CNT_W'(RST_H_BPORCH);
            h_res_q     <= CNT_W'(RST_H_RES);
            v_total_q   <= CNT_W'(RST_V_TOTAL);
            v_sync_q    <= CNT_W'(RST_V_SYNC);
            v_bporch_q  <= CNT_W'(RST_V_BPORCH);
            v_res_q     <= CNT_W'(RST_V_RES);
            cfg_err_q   <= 1'b0;
            req_q       <= 1'b0;
            hs0_q       <= 1'b0;
            vs0_q       <= 1'b0;
            fs0_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            act1_q      <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            fs1_q       <= 1'b0;
            de_q        <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            fs2_q       <= 1'b0;
            rgb_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            h_total_q   <= h_total_d;
            h_sync_q    <= h_sync_d;
            h_bporch_q  <= h_bporch_d;
            h_res_q     <= h_res_d;
            v_total_q   <= v_total_d;
            v_sync_q    <= v_sync_d;
            v_bporch_q  <= v_bporch_d;
            v_res_q     <= v_res_d;
            cfg_err_q   <= cfg_err_d;
            req_q       <= req_d;
            hs0_q       <= hs0_d;
            vs0_q       <= vs0_d;
            fs0_q       <= fs0_d;
            x_q         <= x_d;
            y_q         <= y_d;
            act1_q      <= req_q;
            hs1_q       <= hs0_q;
            vs1_q       <= vs0_q;
            fs1_q       <= fs0_q;
            de_q        <= act1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            fs2_q       <= fs1_q;
            rgb_q       <= rgb_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign O_req         = req_q;
    assign O_x           = x_q;
    assign O_y           = y_q;
    assign O_de          = de_q;
    assign O_rgb         = rgb_q;
    assign O_hs          = hs2_q ^ ~I_hs_pol;
    assign O_vs          = vs2_q ^ ~I_vs_pol;
    assign O_frame_start = fs2_q;
    assign O_frame_cnt   = frame_cnt_q;
    assign O_cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen using small timing modes
module tb_video_timing_gen;
    import video_tg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic        hs_pol = 1'b1, vs_pol = 1'b1;
    logic [23:0] pix_data = '0;
    logic        pat_en = 1'b0;
    logic        O_req, O_hs, O_vs, O_de, O_frame_start, O_cfg_err;
    logic [11:0] O_x, O_y;
    logic [23:0] O_rgb;
    logic [15:0] O_frame_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic mon_en = 1'b0;

    // Mode A matches the reset parameters: 20-cycle lines, 10 lines, 200-cycle frame.
    localparam timing_t MODE_A = '{h_total: 12'd20, h_sync: 12'd2, h_bporch: 12'd3, h_res: 12'd12,
                                   v_total: 12'd10, v_sync: 12'd1, v_bporch: 12'd2, v_res: 12'd5};
    localparam timing_t MODE_B = '{h_total: 12'd16, h_sync: 12'd2, h_bporch: 12'd2, h_res: 12'd10,
                                   v_total: 12'd8,  v_sync: 12'd1, v_bporch: 12'd1, v_res: 12'd4};
    localparam timing_t MODE_BAD = '{h_total: 12'd8, h_sync: 12'd2, h_bporch: 12'd2, h_res: 12'd10,
                                     v_total: 12'd8, v_sync: 12'd1, v_bporch: 12'd1, v_res: 12'd4};

    video_timing_gen #(
        .CNT_W(12), .PIX_W(24), .FCNT_W(16),
        .RST_H_TOTAL(20), .RST_H_SYNC(2), .RST_H_BPORCH(3), .RST_H_RES(12),
        .RST_V_TOTAL(10), .RST_V_SYNC(1), .RST_V_BPORCH(2), .RST_V_RES(5)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_h_total(h_total), .I_h_sync(h_sync), .I_h_bporch(h_bporch), .I_h_res(h_res),
        .I_v_total(v_total), .I_v_sync(v_sync), .I_v_bporch(v_bporch), .I_v_res(v_res),
        .I_hs_pol(hs_pol), .I_vs_pol(vs_pol), .I_pix_data(pix_data),
`ifdef VIDEO_TG_PATTERN_EN
        .I_pat_en(pat_en),
`endif
        .O_req(O_req), .O_x(O_x), .O_y(O_y), .O_hs(O_hs), .O_vs(O_vs), .O_de(O_de),
        .O_rgb(O_rgb), .O_frame_start(O_frame_start), .O_frame_cnt(O_frame_cnt),
        .O_cfg_err(O_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor/source: per-frame statistics, DE/data alignment, and a pixel source that
    // returns {A5, y, x} one cycle after each request.
    int          cyc, de_n, hs_n, vs_n;
    int          last_period, last_de, last_hs, last_vs;
    logic [11:0] fx, fy, lx, ly, last_fx, last_fy, last_lx, last_ly;
    logic        seen;
    logic        req_h1, req_h2;
    logic [23:0] exp_h1, exp_h2, pend;
    logic [11:0] x_h1, x_h2;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_h1 = 0; req_h2 = 0; exp_h1 = 0; exp_h2 = 0; x_h1 = 0; x_h2 = 0;
            pend = 0; pix_data = 0;
            cyc = 0; de_n = 0; hs_n = 0; vs_n = 0; seen = 0;
        end else begin
            if (mon_en) begin
                chk("de_lag", {31'b0, O_de}, {31'b0, req_h2});
                if (O_de) begin
                    if (!pat_en) chk("rgb", {8'b0, O_rgb}, {8'b0, exp_h2});
                    else if (x_h2 == 12'd0) chk("bar_white", {8'b0, O_rgb}, 32'hFFFFFF);
                    else if (x_h2 == 12'd11) chk("bar_black", {8'b0, O_rgb}, 32'h0);
                end else begin
                    chk("rgb_idle", {8'b0, O_rgb}, 32'h0);
                end
            end
            cyc++;
            de_n += int'(O_de);
            hs_n += int'(O_hs == hs_pol);
            vs_n += int'(O_vs == vs_pol);
            if (O_req) begin
                if (!seen) begin fx = O_x; fy = O_y; seen = 1; end
                lx = O_x; ly = O_y;
            end
            if (O_frame_start) begin
                last_period = cyc; last_de = de_n; last_hs = hs_n; last_vs = vs_n;
                last_fx = fx; last_fy = fy; last_lx = lx; last_ly = ly;
                cyc = 0; de_n = 0; hs_n = 0; vs_n = 0; seen = 0;
            end
            req_h2 = req_h1; req_h1 = O_req;
            exp_h2 = exp_h1; exp_h1 = {8'hA5, O_y[7:0], O_x[7:0]};
            x_h2 = x_h1; x_h1 = O_x;
            pix_data = pend;
            pend = O_req ? {8'hA5, O_y[7:0], O_x[7:0]} : 24'h0;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_mode(input timing_t m);
        #1;
        h_total = m.h_total; h_sync = m.h_sync; h_bporch = m.h_bporch; h_res = m.h_res;
        v_total = m.v_total; v_sync = m.v_sync; v_bporch = m.v_bporch; v_res = m.v_res;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!O_frame_start && n < 2000);
        if (n >= 2000) chk("pulse_timeout", 32'd1, 32'd0);
        #1;
    endtask

    task automatic chk_frame(input string tag, input int period, input int de, input int hs,
                             input int vs, input int lxe, input int lye);
        chk({tag, "_period"}, last_period, period);
        chk({tag, "_de"}, last_de, de);
        chk({tag, "_hs"}, last_hs, hs);
        chk({tag, "_vs"}, last_vs, vs);
        chk({tag, "_first_x"}, {20'b0, last_fx}, 32'd0);
        chk({tag, "_first_y"}, {20'b0, last_fy}, 32'd0);
        chk({tag, "_last_x"}, {20'b0, last_lx}, lxe);
        chk({tag, "_last_y"}, {20'b0, last_ly}, lye);
    endtask

    int n;

    initial begin
        set_mode(MODE_A);
        repeat (3) step();
        chk("rst_req", {31'b0, O_req}, 0);
        chk("rst_de", {31'b0, O_de}, 0);
        chk("rst_hs", {31'b0, O_hs}, 0);
        chk("rst_vs", {31'b0, O_vs}, 0);
        chk("rst_rgb", {8'b0, O_rgb}, 0);
        chk("rst_xy", {8'b0, O_y, O_x}, 0);
        chk("rst_fs", {31'b0, O_frame_start}, 0);
        chk("rst_fcnt", {16'b0, O_frame_cnt}, 0);
        chk("rst_err", {31'b0, O_cfg_err}, 0);
        hs_pol = 1'b0;
        #1 chk("rst_hs_neg", {31'b0, O_hs}, 1);
        hs_pol = 1'b1;
        mon_en = 1'b1;

        step(); #1 rst_n = 1'b1;
        wait_pulse(n);
        chk("first_pulse_lat", n, 3);
        chk("first_fcnt", {16'b0, O_frame_cnt}, 1);
        wait_pulse(n);
        chk_frame("mode_a", 200, 60, 20, 20, 11, 4);
        chk("fcnt2", {16'b0, O_frame_cnt}, 2);
        chk("err_a", {31'b0, O_cfg_err}, 0);

        // Mid-frame switch to mode B: current frame stays A.
        repeat (50) step();
        set_mode(MODE_B);
        wait_pulse(n);
        chk("switch_cur_period", last_period, 200);
        wait_pulse(n);
        chk_frame("mode_b", 128, 40, 16, 16, 9, 3);

        // Rejected configuration keeps mode B and flags an error.
        set_mode(MODE_BAD);
        wait_pulse(n);
        chk("bad_err_set", {31'b0, O_cfg_err}, 1);
        chk("bad_period", last_period, 128);
        repeat (10) step();
        set_mode(MODE_A);
        wait_pulse(n);
        chk("bad_kept_b", last_period, 128);
        chk("err_cleared", {31'b0, O_cfg_err}, 0);
        wait_pulse(n);
        chk("back_to_a", last_period, 200);
        chk("fcnt7", {16'b0, O_frame_cnt}, 7);

        // Negative sync polarity.
        hs_pol = 1'b0; vs_pol = 1'b0;
        wait_pulse(n);
        chk_frame("neg_pol", 200, 60, 20, 20, 11, 4);

        // Reset in the middle of an active line.
        repeat (90) step();
        chk("pre_rst_req", {31'b0, O_req}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, O_req}, 0);
        chk("mid_rst_de", {31'b0, O_de}, 0);
        chk("mid_rst_rgb", {8'b0, O_rgb}, 0);
        chk("mid_rst_xy", {8'b0, O_y, O_x}, 0);
        chk("mid_rst_fcnt", {16'b0, O_frame_cnt}, 0);
        chk("mid_rst_hs", {30'b0, O_hs, O_vs}, 3);
        repeat (2) step();
        #1 rst_n = 1'b1;
        wait_pulse(n);
        chk("restart_lat", n, 3);
        chk("restart_fcnt", {16'b0, O_frame_cnt}, 1);
        wait_pulse(n);
        chk_frame("restart", 200, 60, 20, 20, 11, 4);
        hs_pol = 1'b1; vs_pol = 1'b1;

`ifdef VIDEO_TG_PATTERN_EN
        pat_en = 1'b1;
        wait_pulse(n);
        wait_pulse(n);
        pat_en = 1'b0;
        chk("pat_req_de", last_de, 60);
`endif

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised, runtime-reconfigurable video timing generator for the HDMI/DVI output path. It generates HS/VS/DE, pixel coordinates and an early pixel-data request, and registers the returned pixel data aligned to DE. Timing values are programmable per frame through shadowed inputs, so one bitstream covers 800x600, 1024x768, 1280x720 and other modes. It sits between the pixel source (frame buffer or pattern) and the TMDS encoder and runs on the pixel clock.

Parameters:
CNT_W, 12, width of all timing inputs, counters and coordinates
PIX_W, 24, pixel data width
FCNT_W, 16, frame counter width
RST_H_TOTAL/H_SYNC/H_BPORCH/H_RES, 1650/40/220/1280, horizontal shadow values loaded at reset
RST_V_TOTAL/V_SYNC/V_BPORCH/V_RES, 750/5/20/720, vertical shadow values loaded at reset

Ports:
I_clk  in  1  pixel clock
I_rst_n  in  1  reset
I_h_total, I_h_sync, I_h_bporch, I_h_res  in  CNT_W each  requested horizontal timing
I_v_total, I_v_sync, I_v_bporch, I_v_res  in  CNT_W each  requested vertical timing
I_hs_pol, I_vs_pol  in  1 each  1 = positive sync polarity
I_pix_data  in  PIX_W  pixel returned one cycle after O_req
O_req  out  1  pixel request, leads O_de by 2 cycles
O_x, O_y  out  CNT_W each  coordinate of the requested pixel, valid while O_req
O_hs, O_vs, O_de  out  1 each  sync/active outputs
O_rgb  out  PIX_W  pixel data aligned with O_de
O_frame_start  out  1  one-cycle pulse at h_cnt = 0, v_cnt = 0
O_frame_cnt  out  FCNT_W  frame counter
O_cfg_err  out  1  last sampled configuration was rejected

Behaviour:
- Reset is asynchronous and active-low on I_rst_n; the block is clocked on I_clk.
- Reset values:
  - h_cnt = v_cnt = 0.
  - Shadow registers = RST_* values.
  - O_req, O_de, O_frame_start, O_cfg_err = 0; O_x, O_y, O_rgb, O_frame_cnt = 0.
  - O_hs = ~I_hs_pol and O_vs = ~I_vs_pol (inactive level), evaluated combinationally from the polarity inputs.
- Counters:
  - h_cnt runs 0..h_total-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..v_total-1.
  - Both use the shadow values.
- Derived values: h_start = h_sync + h_bporch and v_start = v_sync + v_bporch, computed at CNT_W+1 bits.
- Stage 0 (counter state, cycle t): the following are registered and appear at t+1:
  - hs_i = h_cnt < h_sync; vs_i = v_cnt < v_sync.
  - act = h_cnt in [h_start, h_start + h_res) and v_cnt in [v_start, v_start + v_res).
  - O_req = act; O_x = h_cnt - h_start and O_y = v_cnt - v_start when act, otherwise held.
- Stage 1 and 2:
  - I_pix_data is sampled in the cycle after O_req.
  - O_de, O_hs and O_vs are delayed so that O_de asserts exactly 2 cycles after O_req. O_hs and O_vs keep the same 2-cycle offset relative to act.
  - O_rgb = sampled data while O_de = 1, else 0.
  - O_hs = hs_d ^ ~I_hs_pol; O_vs = vs_d ^ ~I_vs_pol.
- O_frame_start pulses 1 cycle (aligned with the O_hs pipeline) when the counter passes (0, 0). O_frame_cnt increments on that pulse and wraps at 2^FCNT_W.
- Shadow load happens only in the cycle h_cnt = h_total-1 and v_cnt = v_total-1.
  - Accept when all of: h_total ≥ h_sync + h_bporch + h_res; v_total ≥ v_sync + v_bporch + v_res; h_res ≠ 0; v_res ≠ 0; h_sync ≠ 0; v_sync ≠ 0.
  - On accept: load all shadow values and clear O_cfg_err.
  - On reject: keep the previous shadow values and set O_cfg_err.
- Input changes mid-frame have no effect until the next frame boundary.
- Reset mid-frame: all outputs return to reset values immediately and the pipeline flushes; no partial pixel appears after reset release.

Optional Feature:
VIDEO_TG_PATTERN_EN
- Defined: adds input I_pat_en (1 bit). When I_pat_en = 1, O_rgb carries 8 vertical colour bars instead of I_pix_data.
  - Bar index = O_x * 8 / h_res, computed at registered x.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - PIX_W must be 24.
  - O_req still toggles.
- Undefined: the port is absent and O_rgb always carries I_pix_data.

Decomposition:
- Package video_tg_pkg holds:
  - A timing struct typedef (h/v total, sync, bporch, res).
  - The 720p, 1024x768 and 800x600 timing constants.
  - The colour-bar constants.
- One sub-module, video_tg_axis_cnt: a generic total/sync/bporch/res counter with wrap pulse and active flag, instantiated for horizontal and vertical.

Test Plan:
- Reset and 720p defaults:
  - Release reset.
  - Check O_hs high for 40 cycles per line, O_de high for 1280 cycles per line over 720 lines.
  - Check a frame period of 1,237,500 cycles and O_frame_start every frame.
- Data alignment:
  - Drive I_pix_data = {O_y[7:0], O_x[7:0]} registered one cycle after O_req.
  - Check O_rgb at DE pixel n equals the value requested for x = n, O_de lagging O_req by exactly 2 cycles.
- Mode switch:
  - Change the inputs to 800x600 (1056/128/88/800, 628/4/23/600) mid-frame.
  - Check the current frame completes at 720p and the next frame has a period of 663,168 cycles.
- Illegal configuration:
  - Drive h_total = 1000 with h_res = 1280.
  - Check O_cfg_err = 1 at the frame boundary and timing stays 720p.
  - Drive a valid config and check O_cfg_err clears at the next boundary.
- Polarity and reset:
  - Drive I_hs_pol = 0 and check O_hs is low during sync.
  - Assert I_rst_n mid-line and check all outputs return to reset values and the frame restarts at (0, 0) with O_frame_cnt = 0.
- Pattern (macro defined): I_pat_en = 1 at 720p, O_rgb = FFFFFF for x 0..159, 000000 for x 1120..1279.
